// File: rtl/chirp_framer.sv
// chirp_framer: frames decimated chirp samples into N-sample FFT frames.
// Optional drop counter: define CHIRP_FRAMER_DROP_CNT_EN.
module chirp_framer #(
  parameter int DW      = 14,
  parameter int N       = 1024,
  parameter int SKIP    = 16,
  parameter int FIFO_AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  input  logic          ramp_start_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          sof_o,
  output logic          eof_o,
  output logic          busy_o,
  output logic          ovf_o,
  output logic          frame_err_o,
  output logic [15:0]   drop_cnt_o
);

  localparam int IW    = $clog2(N);
  localparam int FW    = DW + 2;
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [IW-1:0] K_LAST = IW'(N - 1);
  localparam logic [7:0] S_LAST =
    (SKIP == 0) ? 8'd0 : 8'(SKIP - 1);

  localparam logic [FIFO_AW:0] P_ONE =
    {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_CAP
  } state_t;

  localparam state_t START_ST =
    (SKIP == 0) ? S_CAP : S_SKIP;

  state_t        state;
  logic [7:0]    skip_cnt;
  logic [IW-1:0] idx;

  logic [FW-1:0]    mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic [FW-1:0]    head;

  logic empty;
  logic full;
  logic pop;
  logic push_req;
  logic push;
  logic drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  =
    (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  assign valid_o  = !empty;
  assign pop      = valid_o && ready_i;
  assign push_req = (state == S_CAP) && valid_i;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Head word is zeroed while the FIFO is empty.
  assign head   = valid_o ? mem[rd_ptr[FIFO_AW-1:0]] : '0;
  assign data_o = head[DW-1:0];
  assign eof_o  = head[DW];
  assign sof_o  = head[DW+1];

  // Sample storage; a full-and-popping write reuses the popped slot.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <=
        {(idx == '0), (idx == K_LAST), data_i};
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
      if (drop) ovf_o  <= 1'b1;
    end
  end

  // Frame FSM: settle after ramp start, then count N samples.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      skip_cnt    <= '0;
      idx         <= '0;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ramp_start_i) begin
            skip_cnt <= '0;
            idx      <= '0;
            state    <= START_ST;
            busy_o   <= 1'b1;
          end
        end
        S_SKIP: begin
          if (ramp_start_i) frame_err_o <= 1'b1;
          if (valid_i) begin
            if (skip_cnt == S_LAST) state <= S_CAP;
            else skip_cnt <= skip_cnt + 8'd1;
          end
        end
        S_CAP: begin
          if (valid_i && idx == K_LAST) begin
            idx      <= '0;
            skip_cnt <= '0;
            if (ramp_start_i) begin
              state <= START_ST;
            end else begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            if (valid_i) idx <= idx + IW'(1);
            if (ramp_start_i) frame_err_o <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHIRP_FRAMER_DROP_CNT_EN
  logic [15:0] drop_cnt;

  // Saturating count of samples lost to a full FIFO.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_chirp_framer.sv
// tb_chirp_framer: scoreboard bench for chirp_framer.
// N=8, SKIP=2, FIFO_AW=2; directed frames with queued expectations.
module tb_chirp_framer;

  localparam int DW = 14;
  localparam int N  = 8;
  localparam int SK = 2;
  localparam int AW = 2;

`ifdef CHIRP_FRAMER_DROP_CNT_EN
  localparam int EXP_DROP = 4;
`else
  localparam int EXP_DROP = 0;
`endif

  logic          clk_i;
  logic          rst_n;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ramp_start_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          sof_o;
  logic          eof_o;
  logic          busy_o;
  logic          ovf_o;
  logic          frame_err_o;
  logic [15:0]   drop_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [DW+1:0] exp_q [$];

  logic rand_en     = 1'b0;
  logic ready_fixed = 1'b1;

  chirp_framer #(
    .DW(DW), .N(N), .SKIP(SK), .FIFO_AW(AW)
  ) dut (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .data_i(data_i),
    .valid_i(valid_i),
    .ramp_start_i(ramp_start_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .sof_o(sof_o),
    .eof_o(eof_o),
    .busy_o(busy_o),
    .ovf_o(ovf_o),
    .frame_err_o(frame_err_o),
    .drop_cnt_o(drop_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input int unsigned act,
                     input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d",
               name, act, exp);
    end
  endtask

  // Ready driver: fixed level, or random with a pop
  // guaranteed at least every third cycle.
  initial begin
    int   run;
    logic r;
    run     = 0;
    ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #2;
      if (rand_en) begin
        if (run >= 2) r = 1'b1;
        else r = 1'($urandom_range(0, 1));
        run = r ? 0 : run + 1;
        ready_i = r;
      end else begin
        ready_i = ready_fixed;
      end
    end
  end

  // Monitor: compare pops, hold while stalled,
  // zero outputs while not valid.
  logic          prev_stall = 1'b0;
  logic [DW+1:0] prev_word;
  logic [DW+1:0] cur;
  logic [DW+1:0] w;

  always @(negedge clk_i) begin
    cur = {sof_o, eof_o, data_o};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!valid_o || cur != prev_word) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h want v=1 %h",
                   valid_o, cur, prev_word);
        end
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h want none",
                   cur);
        end else begin
          w = exp_q.pop_front();
          chk("out_word", 32'(cur), 32'(w));
        end
      end else if (!valid_o) begin
        chk("idle_zero", 32'(cur), 0);
      end
      prev_stall = valid_o && !ready_i;
      prev_word  = cur;
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input int d, input logic rs);
    valid_i      = 1'b1;
    data_i       = DW'(d);
    ramp_start_i = rs;
    tick();
    valid_i      = 1'b0;
    ramp_start_i = 1'b0;
  endtask

  task automatic ramp;
    ramp_start_i = 1'b1;
    tick();
    ramp_start_i = 1'b0;
  endtask

  task automatic expect_w(input int d,
                          input logic s,
                          input logic e);
    exp_q.push_back({s, e, DW'(d)});
  endtask

  task automatic expect_frame(input int base);
    for (int k = 0; k < N; k++)
      expect_w(base + k, k == 0, k == N - 1);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_data",  data_o, 0);
    chk("rst_sof",   sof_o, 0);
    chk("rst_eof",   eof_o, 0);
    chk("rst_busy",  busy_o, 0);
    chk("rst_ovf",   ovf_o, 0);
    chk("rst_ferr",  frame_err_o, 0);
    chk("rst_drop",  drop_cnt_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < 200) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    rst_n        = 1'b1;
    valid_i      = 1'b0;
    ramp_start_i = 1'b0;
    data_i       = '0;
    #2;
    do_reset();

    // Basic frame: 1,2 settle, 3..10 captured.
    expect_frame(3);
    ramp();
    chk("s1_busy_on", busy_o, 1);
    for (int d = 1; d <= 10; d++) send(d, 1'b0);
    chk("s1_busy_off", busy_o, 0);
    send(11, 1'b0);
    send(12, 1'b0);
    drain("s1_drain");

    // Overflow with downstream stalled.
    do_reset();
    ready_fixed = 1'b0;
    tick();
    expect_w(3, 1'b1, 1'b0);
    expect_w(4, 1'b0, 1'b0);
    expect_w(5, 1'b0, 1'b0);
    expect_w(6, 1'b0, 1'b0);
    ramp();
    for (int d = 1; d <= 10; d++) send(d, 1'b0);
    tick();
    chk("s2_valid", valid_o, 1);
    chk("s2_ovf", ovf_o, 1);
    chk("s2_drop", drop_cnt_o, EXP_DROP);
    chk("s2_busy", busy_o, 0);
    ready_fixed = 1'b1;
    drain("s2_drain");
    chk("s2_ovf_sticky", ovf_o, 1);

    // Ramp at capture index 3 is an error.
    do_reset();
    expect_frame(21);
    ramp();
    send(19, 1'b0);
    send(20, 1'b0);
    for (int d = 21; d <= 28; d++)
      send(d, d == 24);
    chk("s3_ferr", frame_err_o, 1);
    chk("s3_busy", busy_o, 0);
    send(29, 1'b0);
    drain("s3_drain");

    // Ramp on last sample restarts cleanly.
    do_reset();
    expect_frame(32);
    expect_frame(42);
    ramp();
    send(30, 1'b0);
    send(31, 1'b0);
    for (int d = 32; d <= 39; d++)
      send(d, d == 39);
    chk("s4_busy_mid", busy_o, 1);
    for (int d = 40; d <= 49; d++) send(d, 1'b0);
    chk("s4_ferr", frame_err_o, 0);
    chk("s4_busy", busy_o, 0);
    drain("s4_drain");

    // Reset mid-frame drops the partial frame.
    do_reset();
    expect_w(52, 1'b1, 1'b0);
    expect_w(53, 1'b0, 1'b0);
    expect_w(54, 1'b0, 1'b0);
    expect_w(55, 1'b0, 1'b0);
    ramp();
    send(50, 1'b0);
    send(51, 1'b0);
    for (int d = 52; d <= 56; d++) send(d, 1'b0);
    do_reset();
    for (int d = 60; d <= 69; d++) send(d, 1'b0);
    chk("s5_busy_idle", busy_o, 0);
    chk("s5_no_out", exp_q.size(), 0);
    expect_frame(72);
    ramp();
    send(70, 1'b0);
    send(71, 1'b0);
    for (int d = 72; d <= 79; d++) send(d, 1'b0);
    drain("s5_drain");

    // Random backpressure over three frames.
    do_reset();
    rand_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      expect_frame(100 + f * 10);
      ramp();
      for (int s = 0; s < SK + N; s++) begin
        if (s < SK) send(90 + s, 1'b0);
        else send(100 + f * 10 + s - SK, 1'b0);
        tick();
        tick();
      end
    end
    rand_en     = 1'b0;
    ready_fixed = 1'b1;
    drain("s6_drain");
    chk("s6_ovf", ovf_o, 0);
    chk("s6_ferr", frame_err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
